// File: rtl/instr_load_ctrl_pkg.sv
// Shared encodings and defaults for the instruction loader.
package instr_load_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT_HI = 3'd0,
    S_WAIT_LO = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_RUN     = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [15:0] HALT_WORD_DEF = 16'hE000;

  // Two 10-bit UART frames at 100 MHz / 115200 baud is ~17.4k cycles; rounded up for margin.
  localparam int IDLE_TIMEOUT_DEF = 20000;

endpackage

// File: rtl/instr_load_ctrl_if.sv
// UART byte input, CPU start request and instruction-memory write/status outputs.
interface instr_load_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              i_start_cpu;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_waddr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_instr_transmit_done;
  logic [ADDR_W-1:0] o_max_addr;
  logic              o_cpu_run_en;
  logic              o_load_error;

  modport master (
    output i_rx_valid, i_rx_data, i_start_cpu,
    input  o_mem_we, o_mem_waddr, o_mem_wdata, o_instr_transmit_done,
           o_max_addr, o_cpu_run_en, o_load_error
  );

  modport slave (
    input  i_rx_valid, i_rx_data, i_start_cpu,
    output o_mem_we, o_mem_waddr, o_mem_wdata, o_instr_transmit_done,
           o_max_addr, o_cpu_run_en, o_load_error
  );
endinterface

// File: rtl/instr_load_ctrl_load_idle_timer.sv
// Saturating idle counter; tc marks the cycle that completes IDLE_TIMEOUT idle cycles.
module load_idle_timer
  import instr_load_ctrl_pkg::*;
#(
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(IDLE_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/instr_load_ctrl.sv
// Loads UART bytes as big-endian 16-bit words into instruction memory, then hands memory to the CPU.
module instr_load_ctrl
  import instr_load_ctrl_pkg::*;
#(
  parameter int          ADDR_W       = 8,
  parameter int          DATA_W       = 16,
  parameter logic [15:0] HALT_WORD    = HALT_WORD_DEF,
  parameter int          IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  instr_load_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] max_q;
  logic [DATA_W-1:0] wdata_q;
  logic              written_q;
  logic              err_q;
  logic              rx;
  logic              tmr_en;
  logic              tmr_tc;
  logic              is_halt;
  logic              at_top;

  assign rx      = bus.i_rx_valid;
  assign is_halt = (wdata_q == HALT_WORD);
  assign at_top  = &waddr_q;

  // The write cycle is counted so the timeout is measured from the last byte.
  assign tmr_en = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO) || (state_q == S_WRITE);

  load_idle_timer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_idle_timer (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (rx),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_WAIT_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_HI: begin
        if (rx)                          state_d = S_WAIT_LO;
        else if (tmr_tc && written_q)    state_d = S_DONE;
      end
      S_WAIT_LO: begin
        if (rx)                          state_d = S_WRITE;
        else if (tmr_tc)                 state_d = S_ERR;
      end
      S_WRITE: begin
        if (is_halt)                     state_d = S_DONE;
        else if (at_top)                 state_d = S_ERR;
        else                             state_d = S_WAIT_HI;
      end
      S_DONE:  if (bus.i_start_cpu)      state_d = S_RUN;
      S_RUN:   if (!bus.i_start_cpu)     state_d = S_DONE;
      S_ERR:                             state_d = S_ERR;
      default:                           state_d = S_WAIT_HI;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q      <= '0;
      addr_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      max_q     <= '0;
      written_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if ((state_q == S_WAIT_HI) && rx) begin
        hi_q <= bus.i_rx_data;
      end
      // Write port registers only change here, so they hold between strobes.
      if ((state_q == S_WAIT_LO) && rx) begin
        waddr_q <= addr_q;
        wdata_q <= {hi_q, bus.i_rx_data};
      end
      if (state_q == S_WRITE) begin
        max_q     <= waddr_q;
        written_q <= 1'b1;
        if (!is_halt && !at_top) begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      if (state_d == S_ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_mem_we              = (state_q == S_WRITE);
  assign bus.o_mem_waddr           = waddr_q;
  assign bus.o_mem_wdata           = wdata_q;
  assign bus.o_instr_transmit_done = (state_q == S_DONE) || (state_q == S_RUN);
  assign bus.o_max_addr            = max_q;
  assign bus.o_cpu_run_en          = (state_q == S_RUN);
  assign bus.o_load_error          = err_q;

endmodule
